// File: rtl/slib_pkg.sv
// Shared definitions for the slib counter family.
// Holds the terminal-mode encoding used by slib_counter_ext. The MODE port
// is two bits wide; the unused code 2'b11 behaves like SLIB_CNT_WRAP.
package slib_pkg;

  typedef enum logic [1:0] {
    SLIB_CNT_WRAP    = 2'b00,
    SLIB_CNT_SAT     = 2'b01,
    SLIB_CNT_ONESHOT = 2'b10
  } slib_cnt_mode_e;

endpackage

// File: rtl/slib_prescaler.sv
// Clock-enable prescaler: asserts TICK once every PRESCALE+1 enabled cycles.
// Ports:
//   CLK      in  clock, rising edge
//   RST      in  asynchronous, active-high reset
//   CLR      in  synchronous restart of the prescale count
//   EN       in  count enable; low holds the prescale count
//   PRESCALE in  divide ratio minus one
//   TICK     out single-cycle tick (combinational from the internal count)
module slib_prescaler #(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic                      EN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TICK
);

  logic [PRESCALE_WIDTH-1:0] cnt_p0;

  // Compare with >= so that lowering PRESCALE below the current count
  // produces a tick on the next enabled cycle instead of a long rollover.
  assign TICK = EN && (cnt_p0 >= PRESCALE);

  // Stage p0: prescale count register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_p0 <= '0;
    end else if (CLR || TICK) begin
      cnt_p0 <= '0;
    end else if (EN) begin
      cnt_p0 <= cnt_p0 + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/slib_counter_ext.sv
// Up/down counter with programmable terminal value, prescaled clock enable,
// wrap / saturate / one-shot terminal modes, a registered terminal-count
// pulse and sticky overflow/underflow flags.
// Ports:
//   CLK       in  clock, rising edge
//   RST       in  asynchronous, active-high reset
//   CLEAR     in  synchronous clear of count and prescaler (highest priority)
//   LOAD      in  synchronous load of D, clamped to LIMIT
//   D         in  load value
//   LIMIT     in  terminal value; count range is 0..LIMIT
//   ENABLE    in  count enable into the prescaler
//   DOWN      in  0 = count up, 1 = count down
//   MODE      in  00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   PRESCALE  in  tick every PRESCALE+1 enabled cycles
//   FLAG_CLR  in  clears OVERFLOW/UNDERFLOW (a same-cycle set wins)
//   Q         out current count
//   TC        out terminal-count pulse, one cycle, cycle after the terminal tick
//   OVERFLOW  out sticky, set by an up-count terminal tick
//   UNDERFLOW out sticky, set by a down-count terminal tick
//   RUNNING   out low while a one-shot is halted
module slib_counter_ext
  import slib_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLEAR,
  input  logic                      LOAD,
  input  logic [WIDTH-1:0]          D,
  input  logic [WIDTH-1:0]          LIMIT,
  input  logic                      ENABLE,
  input  logic                      DOWN,
  input  logic [1:0]                MODE,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      FLAG_CLR,
  output logic [WIDTH-1:0]          Q,
  output logic                      TC,
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW,
  output logic                      RUNNING
);

  logic [WIDTH-1:0] q_p0;
  logic             tc_p0;
  logic             ovf_p0;
  logic             udf_p0;
  logic             run_p0;
  logic             tick;
  logic             at_term;
  slib_cnt_mode_e   mode;

  function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] val,
                                                      input logic [WIDTH-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  assign mode = slib_cnt_mode_e'(MODE);

  // Equality only: if LIMIT is lowered below Q while counting up, Q runs on
  // through the natural 2^WIDTH rollover until it meets LIMIT again.
  assign at_term = DOWN ? (q_p0 == '0) : (q_p0 == LIMIT);

  // A halted one-shot gates the prescaler so it stops advancing too.
  slib_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .CLK     (CLK),
    .RST     (RST),
    .CLR     (CLEAR | LOAD),
    .EN      (ENABLE & run_p0),
    .PRESCALE(PRESCALE),
    .TICK    (tick)
  );

  // Stage p0: count, terminal pulse, flags and run state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_p0   <= '0;
      tc_p0  <= 1'b0;
      ovf_p0 <= 1'b0;
      udf_p0 <= 1'b0;
      run_p0 <= 1'b1;
    end else begin
      tc_p0 <= 1'b0;
      // Clear first; a terminal tick later in this block overrides it.
      if (FLAG_CLR) begin
        ovf_p0 <= 1'b0;
        udf_p0 <= 1'b0;
      end
      if (CLEAR) begin
        q_p0   <= '0;
        run_p0 <= 1'b1;
      end else if (LOAD) begin
        q_p0   <= clamp_to_limit(D, LIMIT);
        run_p0 <= 1'b1;
      end else if (tick) begin
        if (at_term) begin
          tc_p0 <= 1'b1;
          if (DOWN) udf_p0 <= 1'b1;
          else      ovf_p0 <= 1'b1;
          case (mode)
            SLIB_CNT_SAT:     q_p0 <= q_p0;
            SLIB_CNT_ONESHOT: run_p0 <= 1'b0;
            default:          q_p0 <= DOWN ? LIMIT : '0;
          endcase
        end else begin
          q_p0 <= DOWN ? (q_p0 - WIDTH'(1)) : (q_p0 + WIDTH'(1));
        end
      end
    end
  end

  assign Q         = q_p0;
  assign TC        = tc_p0;
  assign OVERFLOW  = ovf_p0;
  assign UNDERFLOW = udf_p0;
  assign RUNNING   = run_p0;

endmodule

// File: tb/tb_slib_counter_ext.sv
// Scoreboard bench for slib_counter_ext: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares after each sample point.
module tb_slib_counter_ext;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d = 8'd0;
  logic [7:0] limit = 8'd5;
  logic       enable = 1'b0;
  logic       down = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] prescale = 4'd0;
  logic       flag_clr = 1'b0;
  logic [7:0] q;
  logic       tc, ovf, udf, run;

  typedef struct packed {
    logic [7:0] q;
    logic       tc;
    logic       ovf;
    logic       udf;
    logic       run;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  slib_counter_ext #(
    .WIDTH(8),
    .PRESCALE_WIDTH(4)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .CLEAR    (clear),
    .LOAD     (load),
    .D        (d),
    .LIMIT    (limit),
    .ENABLE   (enable),
    .DOWN     (down),
    .MODE     (mode),
    .PRESCALE (prescale),
    .FLAG_CLR (flag_clr),
    .Q        (q),
    .TC       (tc),
    .OVERFLOW (ovf),
    .UNDERFLOW(udf),
    .RUNNING  (run)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are presented after every clock edge and after an
  // asynchronous reset assertion; sample 1 time unit later.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
        sb_t  it;
        obs_t act;
        it  = sb.pop_front();
        act = '{q: q, tc: tc, ovf: ovf, udf: udf, run: run};
        checks++;
        if (act !== it.e) begin
          errors++;
          $display("FAIL %s: got q=%0d tc=%b ovf=%b udf=%b run=%b, expected q=%0d tc=%b ovf=%b udf=%b run=%b",
                   it.nm, act.q, act.tc, act.ovf, act.udf, act.run,
                   it.e.q, it.e.tc, it.e.ovf, it.e.udf, it.e.run);
        end
      end
    end
  end

  // Push the expected outputs for the coming edge, then advance one cycle.
  task automatic step(input string nm, input logic [7:0] eq, input logic etc,
                      input logic eovf, input logic eudf, input logic erun);
    sb_t it;
    it.nm = nm;
    it.e  = '{q: eq, tc: etc, ovf: eovf, udf: eudf, run: erun};
    sb.push_back(it);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    step("reset_state", 8'd0, 0, 0, 0, 1);
    rst = 1'b0;

    // Wrap up, LIMIT=5, tick every cycle
    enable = 1'b1;
    step("wrap_q1", 8'd1, 0, 0, 0, 1);
    step("wrap_q2", 8'd2, 0, 0, 0, 1);
    step("wrap_q3", 8'd3, 0, 0, 0, 1);
    step("wrap_q4", 8'd4, 0, 0, 0, 1);
    step("wrap_q5", 8'd5, 0, 0, 0, 1);
    step("wrap_to0", 8'd0, 1, 1, 0, 1);
    step("wrap_q1b", 8'd1, 0, 1, 0, 1);

    // Prescale by 3, count down from 3, freeze mid-prescale
    load = 1'b1; d = 8'd3; prescale = 4'd2; down = 1'b1;
    step("pd_load", 8'd3, 0, 1, 0, 1);
    load = 1'b0;
    step("pd_p1", 8'd3, 0, 1, 0, 1);
    step("pd_p2", 8'd3, 0, 1, 0, 1);
    step("pd_q2", 8'd2, 0, 1, 0, 1);
    step("pd_q2_p1", 8'd2, 0, 1, 0, 1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step("pd_freeze", 8'd2, 0, 1, 0, 1);
    enable = 1'b1;
    step("pd_resume_p2", 8'd2, 0, 1, 0, 1);
    step("pd_q1", 8'd1, 0, 1, 0, 1);
    step("pd_q1_p1", 8'd1, 0, 1, 0, 1);
    step("pd_q1_p2", 8'd1, 0, 1, 0, 1);
    step("pd_q0", 8'd0, 0, 1, 0, 1);
    step("pd_q0_p1", 8'd0, 0, 1, 0, 1);
    step("pd_q0_p2", 8'd0, 0, 1, 0, 1);
    step("pd_wrap_limit", 8'd5, 1, 1, 1, 1);
    step("pd_tc_drop", 8'd5, 0, 1, 1, 1);

    // Saturate at 200
    enable = 1'b0; flag_clr = 1'b1;
    step("flag_clr_idle", 8'd5, 0, 0, 0, 1);
    flag_clr = 1'b0;
    limit = 8'd200; mode = 2'b01; down = 1'b0; prescale = 4'd0;
    load = 1'b1; d = 8'd198;
    step("sat_load", 8'd198, 0, 0, 0, 1);
    load = 1'b0; enable = 1'b1;
    step("sat_199", 8'd199, 0, 0, 0, 1);
    step("sat_200", 8'd200, 0, 0, 0, 1);
    step("sat_hold1", 8'd200, 1, 1, 0, 1);
    step("sat_hold2", 8'd200, 1, 1, 0, 1);
    flag_clr = 1'b1;
    step("sat_set_wins", 8'd200, 1, 1, 0, 1);
    enable = 1'b0;
    step("sat_flag_clr", 8'd200, 0, 0, 0, 1);
    flag_clr = 1'b0;

    // One-shot, LIMIT=4
    limit = 8'd4; mode = 2'b10; clear = 1'b1;
    step("os_clear", 8'd0, 0, 0, 0, 1);
    clear = 1'b0; enable = 1'b1;
    step("os_q1", 8'd1, 0, 0, 0, 1);
    step("os_q2", 8'd2, 0, 0, 0, 1);
    step("os_q3", 8'd3, 0, 0, 0, 1);
    step("os_q4", 8'd4, 0, 0, 0, 1);
    step("os_halt", 8'd4, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step("os_halted", 8'd4, 0, 1, 0, 0);
    load = 1'b1; d = 8'd9;
    step("os_load_clamp", 8'd4, 0, 1, 0, 1);
    load = 1'b0;
    step("os_rehalt", 8'd4, 1, 1, 0, 0);

    // Priority: CLEAR over LOAD over a terminal tick
    mode = 2'b00; enable = 1'b0; flag_clr = 1'b1; load = 1'b1; d = 8'd4;
    step("pri_setup", 8'd4, 0, 0, 0, 1);
    flag_clr = 1'b0; clear = 1'b1; d = 8'd7; enable = 1'b1;
    step("pri_clear_wins", 8'd0, 0, 0, 0, 1);
    clear = 1'b0; limit = 8'd10;
    step("pri_load_tick", 8'd7, 0, 0, 0, 1);
    load = 1'b0; prescale = 4'd2;
    step("pri_p1", 8'd7, 0, 0, 0, 1);
    load = 1'b1;
    step("pri_load_rst_p", 8'd7, 0, 0, 0, 1);
    load = 1'b0;
    step("pri_after_p1", 8'd7, 0, 0, 0, 1);
    step("pri_after_p2", 8'd7, 0, 0, 0, 1);
    step("pri_after_tick", 8'd8, 0, 0, 0, 1);

    // Async reset mid-count with Q=3, OVERFLOW=1
    prescale = 4'd0; limit = 8'd2; load = 1'b1; d = 8'd2;
    step("ar_load", 8'd2, 0, 0, 0, 1);
    load = 1'b0;
    step("ar_wrap", 8'd0, 1, 1, 0, 1);
    limit = 8'd10;
    step("ar_q1", 8'd1, 0, 1, 0, 1);
    step("ar_q2", 8'd2, 0, 1, 0, 1);
    step("ar_q3", 8'd3, 0, 1, 0, 1);
    begin
      sb_t it;
      it.nm = "ar_async";
      it.e  = '{q: 8'd0, tc: 1'b0, ovf: 1'b0, udf: 1'b0, run: 1'b1};
      sb.push_back(it);
    end
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step("ar_resume1", 8'd1, 0, 0, 0, 1);
    step("ar_resume2", 8'd2, 0, 0, 0, 1);

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
